// File: rtl/horner_coeff_feeder.sv
// rtl/horner_coeff_feeder.sv - coefficient table and sequencer feeding a Horner evaluator
module horner_coeff_feeder #(
  parameter int WIDTH   = 32,
  parameter int MAX_DEG = 5,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             start,
  input  logic [IDX_W-1:0] deg,
  input  logic [WIDTH-1:0] x_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic [WIDTH-1:0] h_x,
  output logic [WIDTH-1:0] h_cn,
  output logic             h_first,
  output logic             h_valid,
  input  logic [WIDTH-1:0] h_z,
  input  logic             h_z_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_DEG);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DONE} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             busy_n, done_n, error_n, h_valid_n, h_first_n, tbl_we;
  logic [WIDTH-1:0] result_n, h_x_n, h_cn_n;
  logic [WIDTH-1:0] tbl [MAX_DEG+1];

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      h_valid <= 1'b0;
      h_first <= 1'b0;
      result  <= '0;
      h_x     <= '0;
      h_cn    <= '0;
      for (int i = 0; i <= MAX_DEG; i++) tbl[i] <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      busy    <= busy_n;
      done    <= done_n;
      error   <= error_n;
      h_valid <= h_valid_n;
      h_first <= h_first_n;
      result  <= result_n;
      h_x     <= h_x_n;
      h_cn    <= h_cn_n;
      if (tbl_we) tbl[cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    busy_n    = busy;
    done_n    = 1'b0;
    error_n   = 1'b0;
    h_valid_n = h_valid;
    h_first_n = h_first;
    result_n  = result;
    h_x_n     = h_x;
    h_cn_n    = h_cn;
    tbl_we    = 1'b0;
    case (state)
      S_IDLE: begin
        // An accepted start wins over a table write in the same cycle.
        if (start && deg <= MAX_IDX) begin
          state_n   = S_STREAM;
          idx_n     = deg;
          h_x_n     = x_in;
          busy_n    = 1'b1;
          h_valid_n = 1'b1;
          h_first_n = 1'b1;
          h_cn_n    = tbl[deg];
        end else begin
          error_n = start;
          tbl_we  = cfg_we && (cfg_addr <= MAX_IDX);
        end
      end
      S_STREAM: begin
        h_first_n = 1'b0;
        if (idx == '0) begin
          state_n   = S_WAIT;
          h_valid_n = 1'b0;
          cnt_n     = '0;
        end else begin
          idx_n  = idx - 1'b1;
          h_cn_n = tbl[idx - 1'b1];
        end
      end
      S_WAIT: begin
        cnt_n = cnt_inc;
        // A result arriving on the timeout cycle is still captured.
        if (h_z_valid) begin
          state_n  = S_DONE;
          result_n = h_z;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          cnt_n    = '0;
        end else if (cnt_inc == TMO) begin
          state_n = S_IDLE;
          error_n = 1'b1;
          busy_n  = 1'b0;
          cnt_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_horner_coeff_feeder.sv
// tb/tb_horner_coeff_feeder.sv - directed table-driven bench for horner_coeff_feeder
module tb_horner_coeff_feeder;
  localparam int W   = 32;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [W-1:0]  cfg_data = '0;
  logic          start = 1'b0;
  logic [2:0]    deg = '0;
  logic [W-1:0]  x_in = '0;
  logic          busy, done, error, h_first, h_valid;
  logic [W-1:0]  result, h_x, h_cn;
  logic [W-1:0]  h_z = '0;
  logic          h_z_valid = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  horner_coeff_feeder #(.WIDTH(W), .MAX_DEG(5), .IDX_W(3), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .deg(deg), .x_in(x_in), .busy(busy), .done(done), .result(result),
    .error(error), .h_x(h_x), .h_cn(h_cn), .h_first(h_first), .h_valid(h_valid),
    .h_z(h_z), .h_z_valid(h_z_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  d;
    logic [W-1:0]        x;
    logic [5:0][W-1:0]   c;
    logic [W-1:0]        exp;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_table(input logic [5:0][W-1:0] c);
    for (int i = 0; i < 6; i++) begin
      cfg_we = 1'b1;
      cfg_addr = 3'(i);
      cfg_data = c[i];
      tick();
    end
    cfg_we = 1'b0;
  endtask

  // Starts an evaluation, checks the coefficient stream, models the evaluator.
  task automatic start_and_stream(input int d, input logic [W-1:0] x,
                                  input logic [5:0][W-1:0] c, input bit hold,
                                  output logic [W-1:0] acc);
    acc = '0;
    start = 1'b1;
    deg = 3'(d);
    x_in = x;
    tick();
    if (!hold) start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 1);
    for (int k = d; k >= 0; k--) begin
      chk("h_valid_stream", {31'b0, h_valid}, 1);
      chk("h_cn_stream", h_cn, c[k]);
      chk("h_first_stream", {31'b0, h_first}, (k == d) ? 1 : 0);
      chk("h_x_stable", h_x, x);
      acc = (k == d) ? h_cn : acc * x + h_cn;
      tick();
    end
    chk("h_valid_wait", {31'b0, h_valid}, 0);
  endtask

  task automatic finish_eval(input logic [W-1:0] z, input logic [W-1:0] exp);
    tick();
    tick();
    h_z = z;
    h_z_valid = 1'b1;
    tick();
    h_z_valid = 1'b0;
    chk("done_pulse", {31'b0, done}, 1);
    chk("busy_at_done", {31'b0, busy}, 0);
    chk("error_at_done", {31'b0, error}, 0);
    chk("result", result, exp);
    tick();
    chk("done_clears", {31'b0, done}, 0);
  endtask

  initial begin
    logic [W-1:0] acc;
    logic [5:0][W-1:0] c;
    int first_err;

    vecs[0].d = 2; vecs[0].x = 2; vecs[0].c = '0; vecs[0].exp = 7;
    vecs[0].c[0] = 1; vecs[0].c[1] = 1; vecs[0].c[2] = 1;
    vecs[1].d = 0; vecs[1].x = 2; vecs[1].c = '0; vecs[1].exp = 5;
    vecs[1].c[0] = 5;
    vecs[2].d = 5; vecs[2].x = 2; vecs[2].c = '0; vecs[2].exp = 43;
    vecs[2].c[0] = 3; vecs[2].c[2] = 2; vecs[2].c[5] = 1;
    vecs[3].d = 1; vecs[3].x = 3; vecs[3].c = '0; vecs[3].exp = 4;
    vecs[3].c[0] = 7; vecs[3].c[1] = 32'hFFFF_FFFF;

    #3;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_error", {31'b0, error}, 0);
    chk("rst_h_valid", {31'b0, h_valid}, 0);
    chk("rst_h_first", {31'b0, h_first}, 0);
    chk("rst_result", result, 0);
    chk("rst_h_x", h_x, 0);
    chk("rst_h_cn", h_cn, 0);
    tick();
    rst = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) begin
      write_table(vecs[v].c);
      start_and_stream(vecs[v].d, vecs[v].x, vecs[v].c, 1'b0, acc);
      finish_eval(acc, vecs[v].exp);
    end

    // Degree above MAX_DEG is rejected.
    start = 1'b1; deg = 3'd6; x_in = 9;
    tick();
    start = 1'b0;
    chk("bad_deg_error", {31'b0, error}, 1);
    chk("bad_deg_busy", {31'b0, busy}, 0);
    chk("bad_deg_h_valid", {31'b0, h_valid}, 0);
    tick();
    chk("bad_deg_error_clears", {31'b0, error}, 0);
    chk("bad_deg_h_valid_later", {31'b0, h_valid}, 0);

    // Evaluator silent: error exactly TMO cycles after WAIT entry.
    start_and_stream(0, 1, vecs[3].c, 1'b0, acc);
    first_err = -1;
    for (int t = 1; t <= TMO + 5; t++) begin
      tick();
      if (error && first_err < 0) begin
        first_err = t;
        chk("timeout_busy", {31'b0, busy}, 0);
        chk("timeout_done", {31'b0, done}, 0);
        chk("timeout_result_kept", result, 4);
      end
    end
    chk("timeout_cycle", 32'(first_err), TMO);

    // Result arriving on the timeout cycle is captured.
    start_and_stream(0, 1, vecs[3].c, 1'b0, acc);
    for (int t = 1; t < TMO; t++) tick();
    h_z = 32'h1234; h_z_valid = 1'b1;
    tick();
    h_z_valid = 1'b0;
    chk("late_capture_done", {31'b0, done}, 1);
    chk("late_capture_error", {31'b0, error}, 0);
    chk("late_capture_result", result, 32'h1234);
    tick();

    // start and cfg_we held during the stream must not disturb it.
    c = '0; c[0] = 10; c[1] = 20; c[2] = 30;
    write_table(c);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 99;
    start_and_stream(2, 1, c, 1'b1, acc);
    start = 1'b0; cfg_we = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_error", {31'b0, error}, 0);
    chk("abort_result", result, 0);
    chk("abort_h_x", h_x, 0);
    chk("abort_h_cn", h_cn, 0);
    tick();
    tick();
    chk("abort_no_done", {31'b0, done}, 0);
    chk("abort_no_error", {31'b0, error}, 0);
    rst = 1'b1;
    tick();

    // Table cleared by reset.
    c = '0;
    start_and_stream(2, 5, c, 1'b0, acc);

    // start held across DONE begins the next run on the first IDLE cycle.
    h_z = 32'hABCD; h_z_valid = 1'b1;
    start = 1'b1; deg = 3'd1; x_in = 2;
    tick();
    h_z_valid = 1'b0;
    chk("b2b_done", {31'b0, done}, 1);
    chk("b2b_result", result, 32'hABCD);
    chk("b2b_busy_at_done", {31'b0, busy}, 0);
    tick();
    chk("b2b_idle_busy", {31'b0, busy}, 0);
    chk("b2b_idle_h_valid", {31'b0, h_valid}, 0);
    tick();
    start = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 1);
    chk("b2b_h_valid", {31'b0, h_valid}, 1);
    chk("b2b_h_first", {31'b0, h_first}, 1);
    chk("b2b_h_x", h_x, 2);

    rst = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
